// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mult_share_arbiter
// Brief   : Round-robin arbiter sharing one multiplier datapath between N_REQ
//           requesters. Optional WAIT watchdog via MULT_ARB_WDOG_EN.
// Revision: 1.0
// ============================================================================
module mult_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     rsp_err,
  output logic                     dp_start,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  input  logic                     dp_done,
  input  logic [2*WIDTH-1:0]       dp_result,
  output logic                     busy,
  output logic [15:0]              job_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_g;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;
  logic             w_abort;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (dp_done || w_abort) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (r_state == S_START) gnt[r_g] = 1'b1;
    if (r_state == S_RESP)  rsp_valid[r_g] = 1'b1;
  end

  assign dp_start = (r_state == S_START);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= PTR_W'(N_REQ - 1);
      r_g      <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
      rsp_data <= '0;
      job_cnt  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g  <= w_win;
            dp_a <= a_in[w_win*WIDTH +: WIDTH];
            dp_b <= b_in[w_win*WIDTH +: WIDTH];
          end
        end
        S_WAIT: begin
          if (dp_done)      rsp_data <= dp_result;
          else if (w_abort) rsp_data <= '0;
        end
        S_RESP: begin
          r_ptr   <= r_g;
          job_cnt <= job_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;

  // Counter holds the number of completed WAIT cycles; a done in the last cycle still wins.
  assign w_abort = (r_state == S_WAIT) && !dp_done &&
                   (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (r_state == S_START)     r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
      if (r_state == S_WAIT) begin
        if (dp_done)      rsp_err <= 1'b0;
        else if (w_abort) rsp_err <= 1'b1;
      end
    end
  end
`else
  assign w_abort = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_share_arbiter
// Brief   : Directed self-checking bench for mult_share_arbiter.
// Revision: 1.0
// ============================================================================
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rsp_valid;
  logic [2*W-1:0]   rsp_data;
  logic             rsp_err;
  logic             dp_start;
  logic [W-1:0]     dp_a;
  logic [W-1:0]     dp_b;
  logic             dp_done;
  logic [2*W-1:0]   dp_result;
  logic             busy;
  logic [15:0]      job_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_done(dp_done),
    .dp_result(dp_result), .busy(busy), .job_cnt(job_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; dp_done = 1'b0; dp_result = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Drives one job to completion: dp_done pulsed dly cycles after dp_start is seen.
  task automatic serve(input int dly, input logic [2*W-1:0] res,
                       output logic [N-1:0] gv, output logic [N-1:0] rv,
                       output logic [W-1:0] da, output logic [W-1:0] db,
                       output int ngnt, output int cyc);
    int since;
    since = -1; gv = '0; rv = '0; da = '0; db = '0; ngnt = 0; cyc = 0;
    for (int c = 0; c < 40 && rv == '0; c++) begin
      tick();
      cyc++;
      dp_done = 1'b0;
      if (gnt != '0) begin gv = gnt; da = dp_a; db = dp_b; ngnt++; end
      if (dp_start) since = 0;
      else if (since >= 0) since++;
      if (rsp_valid != '0) rv = rsp_valid;
      else if (since == dly) begin dp_done = 1'b1; dp_result = res; end
    end
    dp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; dp_done = 1'b0; dp_result = '0; a_in = '0; b_in = '0;
    #3;
    tests++;
    if ({gnt, rsp_valid, dp_start, busy} !== '0) begin
      fails++; $display("FAIL reset_async got=%b exp=0", {gnt, rsp_valid, dp_start, busy});
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++;
      if ({gnt, rsp_valid, dp_start, busy, rsp_err, job_cnt, dp_a, dp_b, rsp_data} !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got gnt=%b rv=%b st=%b busy=%b err=%b cnt=%h a=%h b=%h d=%h exp all 0",
                 c, gnt, rsp_valid, dp_start, busy, rsp_err, job_cnt, dp_a, dp_b, rsp_data);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] gv, rv;
    logic [W-1:0] da, db;
    int ngnt, cyc;
    set_ops(2, 16'h0003, 16'h0005);
    req = 4'b0100;
    serve(3, 32'h0000_000F, gv, rv, da, db, ngnt, cyc);
    req = '0;
    tests++;
    if (gv !== 4'b0100 || ngnt != 1) begin
      fails++; $display("FAIL single_gnt got=%b x%0d exp=0100 x1", gv, ngnt);
    end
    tests++;
    if (da !== 16'h0003 || db !== 16'h0005) begin
      fails++; $display("FAIL single_ops got a=%h b=%h exp a=0003 b=0005", da, db);
    end
    tests++;
    if (rv !== 4'b0100 || rsp_data !== 32'h0000_000F || rsp_err !== 1'b0) begin
      fails++; $display("FAIL single_rsp got rv=%b d=%h e=%b exp rv=0100 d=0000000f e=0", rv, rsp_data, rsp_err);
    end
    tick();
    tests++;
    if (job_cnt !== 16'd1 || busy !== 1'b0 || rsp_valid !== '0) begin
      fails++; $display("FAIL single_done got cnt=%0d busy=%b rv=%b exp cnt=1 busy=0 rv=0", job_cnt, busy, rsp_valid);
    end
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || rsp_data !== 32'h0000_000F) begin
      fails++; $display("FAIL single_hold got busy=%b d=%h exp busy=0 d=0000000f", busy, rsp_data);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] gv, rv, exp_g;
    logic [W-1:0] da, db;
    int ngnt, cyc;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), W'(i + 10));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      serve(1, 32'(100 + k), gv, rv, da, db, ngnt, cyc);
      tests++;
      if (gv !== exp_g || rv !== exp_g || ngnt != 1) begin
        fails++; $display("FAIL contention_order job=%0d got g=%b rv=%b x%0d exp %b x1", k, gv, rv, ngnt, exp_g);
      end
      tests++;
      if (da !== W'(k % 4 + 1) || db !== W'(k % 4 + 10) || rsp_data !== 32'(100 + k)) begin
        fails++; $display("FAIL contention_data job=%0d got a=%h b=%h d=%h exp a=%h b=%h d=%h",
                          k, da, db, rsp_data, k % 4 + 1, k % 4 + 10, 100 + k);
      end
    end
    req = '0;
    tick();
    tests++;
    if (job_cnt !== 16'd5) begin
      fails++; $display("FAIL contention_cnt got=%0d exp=5", job_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] gv, rv;
    logic [W-1:0] da, db;
    int ngnt, cyc;
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      serve(1, 32'hA000 + 32'(k), gv, rv, da, db, ngnt, cyc);
      tests++;
      if (cyc != ((k == 0) ? 3 : 4) || rv !== ((k % 2 == 0) ? 4'b0001 : 4'b0010)) begin
        fails++; $display("FAIL b2b_period job=%0d got cyc=%0d rv=%b exp cyc=%0d rv=%b",
                          k, cyc, rv, (k == 0) ? 3 : 4, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_stray_done();
    do_reset();
    dp_done = 1'b1; dp_result = 32'hDEAD;
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      fails++; $display("FAIL stray_idle got busy=%b rv=%b exp 0 0", busy, rsp_valid);
    end
    req = 4'b0001;
    tick();
    tick();
    dp_done = 1'b0; req = '0;
    tick();
    tests++;
    if (busy !== 1'b1 || rsp_valid !== '0) begin
      fails++; $display("FAIL stray_start got busy=%b rv=%b exp busy=1 rv=0", busy, rsp_valid);
    end
    dp_done = 1'b1; dp_result = 32'h55;
    tick();
    dp_done = 1'b0;
    tests++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h55) begin
      fails++; $display("FAIL stray_rsp got rv=%b d=%h exp rv=0001 d=00000055", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_ops(3, 16'h7777, 16'h8888);
    req = 4'b1000;
    tick(); tick();
    req = '0;
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({gnt, rsp_valid, dp_start, busy} !== '0 || dp_a !== '0 || dp_b !== '0 || job_cnt !== '0) begin
      fails++; $display("FAIL midwait_reset got gnt=%b rv=%b st=%b busy=%b a=%h b=%h cnt=%0d exp all 0",
                        gnt, rsp_valid, dp_start, busy, dp_a, dp_b, job_cnt);
    end
    dp_done = 1'b1; dp_result = 32'h99;
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      fails++; $display("FAIL midwait_norsp got rv=%b busy=%b exp 0 0", rsp_valid, busy);
    end
    dp_done = 1'b0;
    set_ops(1, 16'h1234, 16'h0002);
    req = 4'b0010;
    tick();
    tests++;
    if (gnt !== 4'b0010 || dp_a !== 16'h1234) begin
      fails++; $display("FAIL midwait_regnt got gnt=%b a=%h exp 0010 1234", gnt, dp_a);
    end
    req = '0;
    tick();
    dp_done = 1'b1; dp_result = 32'h2468;
    tick();
    dp_done = 1'b0;
    tests++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 32'h2468 || job_cnt !== 16'd0) begin
      fails++; $display("FAIL midwait_rsp got rv=%b d=%h cnt=%0d exp 0010 00002468 0", rsp_valid, rsp_data, job_cnt);
    end
    tick();
  endtask

`ifdef MULT_ARB_WDOG_EN
  task automatic test_watchdog();
    logic [N-1:0] gv, rv;
    logic [W-1:0] da, db;
    int ngnt, cyc, early;
    do_reset();
    set_ops(0, 16'h0011, 16'h0022);
    req = 4'b0001;
    serve(1, 32'h0000_ABCD, gv, rv, da, db, ngnt, cyc);
    req = '0;
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    early = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (rsp_valid != '0) early++;
    end
    tests++;
    if (early != 0) begin
      fails++; $display("FAIL wdog_early got %0d early responses exp 0", early);
    end
    tick();
    tests++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== '0) begin
      fails++; $display("FAIL wdog_abort got rv=%b e=%b d=%h exp 0001 1 00000000", rsp_valid, rsp_err, rsp_data);
    end
    dp_done = 1'b1; dp_result = 32'h77;
    tick(); tick();
    dp_done = 1'b0;
    tests++;
    if (rsp_valid !== '0 || busy !== 1'b0 || job_cnt !== 16'd2) begin
      fails++; $display("FAIL wdog_late got rv=%b busy=%b cnt=%0d exp 0 0 2", rsp_valid, busy, job_cnt);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_stray_done();
    test_reset_mid_wait();
`ifdef MULT_ARB_WDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
